// File: rtl/accum_frame.sv
// Frame accumulator: add/sub/load/clear on a registered sum, with a result
// and sticky carry/borrow flag captured every FRAME counted operations.
`timescale 1ns/1ps
module accum_frame #(
    parameter int WIDTH    = 8,
    parameter int FRAME    = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       valid_i,
    input  logic [1:0]                 mode_i,
    output logic [WIDTH-1:0]           sum_o,
    output logic [WIDTH-1:0]           reg_sum_o,
    output logic                       ovf_o,
    output logic [WIDTH-1:0]           result_o,
    output logic                       result_ovf_o,
    output logic                       done_o,
    output logic [$clog2(FRAME+1)-1:0] count_o
);
    localparam int CW = $clog2(FRAME + 1);
    localparam logic [CW-1:0] FRAME_CNT = CW'(FRAME);
    localparam logic [1:0] MODE_ADD  = 2'b00;
    localparam logic [1:0] MODE_SUB  = 2'b01;
    localparam logic [1:0] MODE_LOAD = 2'b10;
    localparam logic [1:0] MODE_CLR  = 2'b11;

    logic [WIDTH-1:0] reg_sum_q, reg_sum_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             result_ovf_q, result_ovf_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   add_full, sub_full;
    logic [WIDTH-1:0] sum_c;
    logic             flag_c;
    logic [CW-1:0]    op_count;
    logic             op_ovf;

    // The extra top bit of each result is the carry (add) or borrow (sub).
    assign add_full = {1'b0, reg_sum_q} + {1'b0, data_i};
    assign sub_full = {1'b0, reg_sum_q} - {1'b0, data_i};

    always_comb begin
        sum_c  = '0;
        flag_c = 1'b0;
        case (mode_i)
            MODE_ADD: begin
                flag_c = add_full[WIDTH];
                sum_c  = (SATURATE && flag_c) ? '1 : add_full[WIDTH-1:0];
            end
            MODE_SUB: begin
                flag_c = sub_full[WIDTH];
                sum_c  = (SATURATE && flag_c) ? '0 : sub_full[WIDTH-1:0];
            end
            MODE_LOAD: sum_c = data_i;
            default:   sum_c = '0;
        endcase
    end

    // Load starts a fresh frame at count 1 with the flag cleared.
    assign op_count = (mode_i == MODE_LOAD) ? CW'(1) : count_q + CW'(1);
    assign op_ovf   = (mode_i == MODE_LOAD) ? 1'b0 : (ovf_q | flag_c);

    always_comb begin
        reg_sum_d    = reg_sum_q;
        count_d      = count_q;
        ovf_d        = ovf_q;
        result_d     = result_q;
        result_ovf_d = result_ovf_q;
        done_d       = 1'b0;
        if (valid_i) begin
            if (mode_i == MODE_CLR) begin
                reg_sum_d = '0;
                count_d   = '0;
                ovf_d     = 1'b0;
            end else if (op_count == FRAME_CNT) begin
                result_d     = sum_c;
                result_ovf_d = op_ovf;
                reg_sum_d    = '0;
                count_d      = '0;
                ovf_d        = 1'b0;
                done_d       = 1'b1;
            end else begin
                reg_sum_d = sum_c;
                count_d   = op_count;
                ovf_d     = op_ovf;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reg_sum_q    <= '0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
            result_q     <= '0;
            result_ovf_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            reg_sum_q    <= reg_sum_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
            result_q     <= result_d;
            result_ovf_q <= result_ovf_d;
            done_q       <= done_d;
        end
    end

    assign sum_o        = sum_c;
    assign reg_sum_o    = reg_sum_q;
    assign ovf_o        = ovf_q;
    assign result_o     = result_q;
    assign result_ovf_o = result_ovf_q;
    assign done_o       = done_q;
    assign count_o      = count_q;
endmodule

// File: tb/tb_accum_frame.sv
// Bench for accum_frame: three instances (wrap FRAME=4, clamp FRAME=4, wrap FRAME=1)
// share one stimulus stream and are checked against an arithmetic model.
`timescale 1ns/1ps
module tb_accum_frame;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] data = 4'd0;
    logic       valid = 1'b0;
    logic [1:0] mode = 2'd0;

    always #5 clk = ~clk;

    logic [3:0] sum0, reg0, res0, sum1, reg1, res1, sum2, reg2, res2;
    logic       ovf0, rovf0, done0, ovf1, rovf1, done1, ovf2, rovf2, done2;
    logic [2:0] cnt0, cnt1;
    logic [0:0] cnt2;

    accum_frame #(.WIDTH(4), .FRAME(4), .SATURATE(1'b0)) u0 (
        .clk_i(clk), .rst_ni(rst_n), .data_i(data), .valid_i(valid), .mode_i(mode),
        .sum_o(sum0), .reg_sum_o(reg0), .ovf_o(ovf0), .result_o(res0),
        .result_ovf_o(rovf0), .done_o(done0), .count_o(cnt0));
    accum_frame #(.WIDTH(4), .FRAME(4), .SATURATE(1'b1)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .data_i(data), .valid_i(valid), .mode_i(mode),
        .sum_o(sum1), .reg_sum_o(reg1), .ovf_o(ovf1), .result_o(res1),
        .result_ovf_o(rovf1), .done_o(done1), .count_o(cnt1));
    accum_frame #(.WIDTH(4), .FRAME(1), .SATURATE(1'b0)) u2 (
        .clk_i(clk), .rst_ni(rst_n), .data_i(data), .valid_i(valid), .mode_i(mode),
        .sum_o(sum2), .reg_sum_o(reg2), .ovf_o(ovf2), .result_o(res2),
        .result_ovf_o(rovf2), .done_o(done2), .count_o(cnt2));

    logic [3:0] a_sum[3], a_reg[3], a_res[3];
    logic       a_ovf[3], a_rovf[3], a_done[3];
    logic [2:0] a_cnt[3];
    assign a_sum[0] = sum0;  assign a_sum[1] = sum1;  assign a_sum[2] = sum2;
    assign a_reg[0] = reg0;  assign a_reg[1] = reg1;  assign a_reg[2] = reg2;
    assign a_res[0] = res0;  assign a_res[1] = res1;  assign a_res[2] = res2;
    assign a_ovf[0] = ovf0;  assign a_ovf[1] = ovf1;  assign a_ovf[2] = ovf2;
    assign a_rovf[0] = rovf0; assign a_rovf[1] = rovf1; assign a_rovf[2] = rovf2;
    assign a_done[0] = done0; assign a_done[1] = done1; assign a_done[2] = done2;
    assign a_cnt[0] = cnt0;  assign a_cnt[1] = cnt1;  assign a_cnt[2] = {2'b00, cnt2};

    int checks = 0;
    int errors = 0;

    // Reference model state, one slot per instance
    int m_reg[3], m_cnt[3], m_res[3];
    bit m_ovf[3], m_rovf[3], m_done[3];
    int exp_sum_pre[3];
    logic [3:0] sum_seen[3];

    function automatic int frame_of(int k);
        return (k == 2) ? 1 : 4;
    endfunction

    function automatic bit sat_of(int k);
        return (k == 1);
    endfunction

    function automatic int model_sum(int k, int m, int d, output bit flag);
        int s;
        flag = 1'b0;
        case (m)
            0: begin
                s = m_reg[k] + d;
                if (s > 15) begin flag = 1'b1; s = sat_of(k) ? 15 : s - 16; end
            end
            1: begin
                s = m_reg[k] - d;
                if (s < 0) begin flag = 1'b1; s = sat_of(k) ? 0 : s + 16; end
            end
            2: s = d;
            default: s = 0;
        endcase
        return s;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_reg[k] = 0; m_cnt[k] = 0; m_res[k] = 0;
            m_ovf[k] = 0; m_rovf[k] = 0; m_done[k] = 0;
        end
    endtask

    task automatic model_step(int k, bit v, int m, int d);
        bit fl;
        int s, nc;
        bit no;
        s = model_sum(k, m, d, fl);
        m_done[k] = 0;
        if (v) begin
            if (m == 3) begin
                m_reg[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
            end else begin
                nc = (m == 2) ? 1 : m_cnt[k] + 1;
                no = (m == 2) ? 1'b0 : (m_ovf[k] | fl);
                if (nc == frame_of(k)) begin
                    m_res[k] = s; m_rovf[k] = no; m_done[k] = 1;
                    m_reg[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
                end else begin
                    m_reg[k] = s; m_cnt[k] = nc; m_ovf[k] = no;
                end
            end
        end
    endtask

    // Drive one cycle; captures the combinational sum before the edge.
    task automatic cycle(bit v, int m, int d);
        bit f;
        valid = v;
        mode  = m[1:0];
        data  = d[3:0];
        #1;
        for (int k = 0; k < 3; k++) begin
            sum_seen[k]    = a_sum[k];
            exp_sum_pre[k] = model_sum(k, m, d, f);
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k, v, m, d);
        #1;
        $display("t=%0t v=%0d mode=%0d data=%0d | u0 reg=%0d cnt=%0d ovf=%0d done=%0d res=%0d | u1 reg=%0d | u2 res=%0d done=%0d",
                 $time, v, m, d, reg0, cnt0, ovf0, done0, res0, reg1, res2, done2);
    endtask

    task automatic test_reset();
        valid = 1'b1; mode = 2'd2; data = 4'd9;
        @(negedge clk);
        checks++; if (reg0 !== 4'd0) begin errors++; $display("FAIL reset_reg: got %0d expected 0", reg0); end
        checks++; if (cnt0 !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", cnt0); end
        checks++; if ({ovf0, rovf0, done0} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {ovf0, rovf0, done0}); end
        checks++; if (res0 !== 4'd0) begin errors++; $display("FAIL reset_res: got %0d expected 0", res0); end
        checks++; if (sum0 !== 4'd9) begin errors++; $display("FAIL reset_sum_load: got %0d expected 9", sum0); end
        mode = 2'd1; data = 4'd3; #1;
        checks++; if (sum0 !== 4'd13) begin errors++; $display("FAIL reset_sum_sub_wrap: got %0d expected 13", sum0); end
        checks++; if (sum1 !== 4'd0) begin errors++; $display("FAIL reset_sum_sub_clamp: got %0d expected 0", sum1); end
        valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_basic();
        int vals[4] = '{3, 5, 2, 1};
        int exp_reg[3] = '{3, 8, 10};
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, vals[i]);
            checks++; if (reg0 !== 4'(exp_reg[i])) begin errors++; $display("FAIL basic_reg%0d: got %0d expected %0d", i, reg0, exp_reg[i]); end
            checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL basic_nodone%0d: got %0d expected 0", i, done0); end
        end
        cycle(1, 0, vals[3]);
        checks++; if (res0 !== 4'd11 || rovf0 !== 1'b0) begin errors++; $display("FAIL basic_result: got %0d/%0d expected 11/0", res0, rovf0); end
        checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL basic_done: got %0d expected 1", done0); end
        checks++; if (reg0 !== 4'd0 || cnt0 !== 3'd0) begin errors++; $display("FAIL basic_restart: got reg %0d cnt %0d expected 0 0", reg0, cnt0); end
        cycle(0, 0, 0);
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %0d expected 0", done0); end
    endtask

    task automatic test_clear();
        cycle(1, 0, 1);
        cycle(1, 0, 1);
        cycle(1, 3, 0);
        checks++; if (done0 !== 1'b0 || cnt0 !== 3'd0 || reg0 !== 4'd0) begin errors++; $display("FAIL clear_state: got done %0d cnt %0d reg %0d expected 0 0 0", done0, cnt0, reg0); end
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 1);
            checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL clear_early_done%0d: got %0d expected 0", i, done0); end
        end
        cycle(1, 0, 1);
        checks++; if (done0 !== 1'b1 || res0 !== 4'd4) begin errors++; $display("FAIL clear_frame: got done %0d res %0d expected 1 4", done0, res0); end
    endtask

    task automatic test_wrap();
        cycle(1, 0, 9);
        cycle(1, 0, 9);
        checks++; if (reg0 !== 4'd2 || ovf0 !== 1'b1) begin errors++; $display("FAIL wrap_add: got %0d/%0d expected 2/1", reg0, ovf0); end
        checks++; if (reg1 !== 4'd15 || ovf1 !== 1'b1) begin errors++; $display("FAIL clamp_add: got %0d/%0d expected 15/1", reg1, ovf1); end
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        checks++; if (res0 !== 4'd2 || rovf0 !== 1'b1 || ovf0 !== 1'b0) begin errors++; $display("FAIL wrap_result: got %0d/%0d/%0d expected 2/1/0", res0, rovf0, ovf0); end
        checks++; if (res1 !== 4'd15 || rovf1 !== 1'b1) begin errors++; $display("FAIL clamp_result: got %0d/%0d expected 15/1", res1, rovf1); end
        cycle(1, 3, 0);
        cycle(1, 2, 2);
        cycle(1, 1, 5);
        checks++; if (reg1 !== 4'd0 || ovf1 !== 1'b1) begin errors++; $display("FAIL clamp_sub: got %0d/%0d expected 0/1", reg1, ovf1); end
        checks++; if (reg0 !== 4'd13 || ovf0 !== 1'b1 || cnt0 !== 3'd2) begin errors++; $display("FAIL wrap_sub: got %0d/%0d/%0d expected 13/1/2", reg0, ovf0, cnt0); end
    endtask

    task automatic test_gap();
        cycle(1, 3, 0);
        cycle(1, 0, 4);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 7);
            checks++; if (done0 !== 1'b0 || reg0 !== 4'd4 || cnt0 !== 3'd1) begin errors++; $display("FAIL gap_hold%0d: got done %0d reg %0d cnt %0d expected 0 4 1", i, done0, reg0, cnt0); end
        end
        cycle(1, 0, 1);
        checks++; if (reg0 !== 4'd5 || cnt0 !== 3'd2) begin errors++; $display("FAIL gap_resume: got reg %0d cnt %0d expected 5 2", reg0, cnt0); end
    endtask

    task automatic test_async_reset();
        cycle(1, 3, 0);
        cycle(1, 0, 6);
        cycle(1, 0, 6);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (reg0 !== 4'd0 || cnt0 !== 3'd0 || ovf0 !== 1'b0) begin errors++; $display("FAIL async_state: got reg %0d cnt %0d ovf %0d expected 0 0 0", reg0, cnt0, ovf0); end
        checks++; if (res0 !== 4'd0 || rovf0 !== 1'b0 || done0 !== 1'b0) begin errors++; $display("FAIL async_result: got res %0d rovf %0d done %0d expected 0 0 0", res0, rovf0, done0); end
        checks++; if (sum0 !== 4'd6) begin errors++; $display("FAIL async_sum: got %0d expected 6", sum0); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cycle(1, 0, 1);
        checks++; if (res0 !== 4'd4 || done0 !== 1'b1) begin errors++; $display("FAIL async_frame: got res %0d done %0d expected 4 1", res0, done0); end
    endtask

    task automatic test_frame1();
        cycle(1, 3, 0);
        cycle(1, 2, 7);
        checks++; if (done2 !== 1'b1 || res2 !== 4'd7) begin errors++; $display("FAIL f1_load: got done %0d res %0d expected 1 7", done2, res2); end
        cycle(1, 0, 3);
        checks++; if (done2 !== 1'b1 || res2 !== 4'd3) begin errors++; $display("FAIL f1_back_to_back: got done %0d res %0d expected 1 3", done2, res2); end
        cycle(1, 1, 5);
        checks++; if (done2 !== 1'b1 || res2 !== 4'd11 || rovf2 !== 1'b1) begin errors++; $display("FAIL f1_sub: got done %0d res %0d rovf %0d expected 1 11 1", done2, res2, rovf2); end
        cycle(0, 0, 0);
        checks++; if (done2 !== 1'b0) begin errors++; $display("FAIL f1_idle: got %0d expected 0", done2); end
    endtask

    task automatic test_random();
        int r, m;
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            m = (r < 5) ? 0 : (r < 8) ? 1 : (r == 8) ? 2 : 3;
            cycle($urandom_range(0, 3) != 0, m, $urandom_range(0, 15));
            for (int k = 0; k < 3; k++) begin
                checks++; if (sum_seen[k] !== 4'(exp_sum_pre[k])) begin errors++; $display("FAIL rand_sum u%0d n%0d: got %0d expected %0d", k, n, sum_seen[k], exp_sum_pre[k]); end
                checks++; if (a_reg[k] !== 4'(m_reg[k])) begin errors++; $display("FAIL rand_reg u%0d n%0d: got %0d expected %0d", k, n, a_reg[k], m_reg[k]); end
                checks++; if (a_cnt[k] !== 3'(m_cnt[k])) begin errors++; $display("FAIL rand_cnt u%0d n%0d: got %0d expected %0d", k, n, a_cnt[k], m_cnt[k]); end
                checks++; if (a_ovf[k] !== m_ovf[k]) begin errors++; $display("FAIL rand_ovf u%0d n%0d: got %0d expected %0d", k, n, a_ovf[k], m_ovf[k]); end
                checks++; if (a_res[k] !== 4'(m_res[k]) || a_rovf[k] !== m_rovf[k]) begin errors++; $display("FAIL rand_result u%0d n%0d: got %0d/%0d expected %0d/%0d", k, n, a_res[k], a_rovf[k], m_res[k], m_rovf[k]); end
                checks++; if (a_done[k] !== m_done[k]) begin errors++; $display("FAIL rand_done u%0d n%0d: got %0d expected %0d", k, n, a_done[k], m_done[k]); end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_clear();
        test_wrap();
        test_gap();
        test_async_reset();
        test_frame1();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
